// File: rtl/edge_detect_multi_if.sv
// Bundles the edge detector's line inputs, controls and edge reports.
// The master drives lines and controls; the slave (the detector) returns the reports.
interface edge_detect_multi_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 8
);
    logic [NUM_CH-1:0] din;
    logic [1:0]        mode;
    logic              clear;
    logic [NUM_CH-1:0] edge_pulse;
    logic              edge_all;
    logic [NUM_CH-1:0] edge_sticky;
    logic [CNT_W-1:0]  edge_count;

    modport master (
        output din, mode, clear,
        input  edge_pulse, edge_all, edge_sticky, edge_count
    );

    modport slave (
        input  din, mode, clear,
        output edge_pulse, edge_all, edge_sticky, edge_count
    );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: synchroniser, persistence filter, mode-gated edge pulses,
// all-channel coincidence flag, sticky flags and a saturating edge counter.
module edge_detect_multi #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 1,
    parameter int unsigned CNT_W       = 8,
    parameter logic        RST_VAL     = 1'b1
) (
    input  logic               clk,
    input  logic               n_rst,
    edge_detect_multi_if.slave bus
);
    localparam int unsigned       FCNT_W    = $clog2(FILT_LEN) + 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_lvl;

    logic [NUM_CH-1:0] flt_q;
    logic [NUM_CH-1:0] flt_nxt;
    logic [FCNT_W-1:0] fcnt_q   [NUM_CH];
    logic [FCNT_W-1:0] fcnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] accept;

    logic              rise_en;
    logic              fall_en;
    logic [NUM_CH-1:0] pulse_nxt;
    logic              all_nxt;

    logic [NUM_CH-1:0] edge_pulse_q;
    logic              edge_all_q;
    logic [NUM_CH-1:0] edge_sticky_q;
    logic [CNT_W-1:0]  edge_count_q;

    // Metastability shift chain per channel
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {NUM_CH{RST_VAL}};
            end
        end else begin
            sync_q[0] <= bus.din;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // A new level is accepted once it has differed from flt for FILT_LEN consecutive clocks
    always_comb begin
        accept  = '0;
        flt_nxt = flt_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            fcnt_nxt[i] = '0;
            if (sync_lvl[i] != flt_q[i]) begin
                if (fcnt_q[i] == FCNT_LAST) begin
                    accept[i]  = 1'b1;
                    flt_nxt[i] = sync_lvl[i];
                end else begin
                    fcnt_nxt[i] = fcnt_q[i] + FCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flt_q <= {NUM_CH{RST_VAL}};
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            flt_q <= flt_nxt;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                fcnt_q[i] <= fcnt_nxt[i];
            end
        end
    end

    // Mode gating; mode 11 enables neither direction
    always_comb begin
        rise_en   = (bus.mode == MODE_RISE) || (bus.mode == MODE_BOTH);
        fall_en   = (bus.mode == MODE_FALL) || (bus.mode == MODE_BOTH);
        pulse_nxt = accept & ((sync_lvl & {NUM_CH{rise_en}}) | (~sync_lvl & {NUM_CH{fall_en}}));
        all_nxt   = (&accept) && (((&sync_lvl) && rise_en) || ((~|sync_lvl) && fall_en));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            edge_pulse_q <= '0;
            edge_all_q   <= 1'b0;
        end else begin
            edge_pulse_q <= pulse_nxt;
            edge_all_q   <= all_nxt;
        end
    end

    // Sticky flags and counter follow the registered pulse; a pulse beats a same-cycle clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            edge_sticky_q <= '0;
            edge_count_q  <= '0;
        end else begin
            edge_sticky_q <= (bus.clear ? '0 : edge_sticky_q) | edge_pulse_q;
            if (bus.clear) begin
                edge_count_q <= CNT_W'(|edge_pulse_q);
            end else if ((|edge_pulse_q) && (edge_count_q != CNT_MAX)) begin
                edge_count_q <= edge_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.edge_pulse  = edge_pulse_q;
    assign bus.edge_all    = edge_all_q;
    assign bus.edge_sticky = edge_sticky_q;
    assign bus.edge_count  = edge_count_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: two configurations (FILT_LEN 1/CNT_W 8 and FILT_LEN 4/CNT_W 4)
// share stimulus and are checked every cycle against a history-window reference model.
module tb_edge_detect_multi;
    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] din;
    logic [1:0] mode;
    logic       clear;
    logic       cmp_en = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    edge_detect_multi_if #(.NUM_CH(2), .CNT_W(8)) bus0 ();
    edge_detect_multi_if #(.NUM_CH(2), .CNT_W(4)) bus1 ();

    assign bus0.din = din;  assign bus0.mode = mode;  assign bus0.clear = clear;
    assign bus1.din = din;  assign bus1.mode = mode;  assign bus1.clear = clear;

    edge_detect_multi #(.NUM_CH(2), .SYNC_STAGES(2), .FILT_LEN(1), .CNT_W(8), .RST_VAL(1'b1))
        dut0 (.clk(clk), .n_rst(n_rst), .bus(bus0.slave));
    edge_detect_multi #(.NUM_CH(2), .SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(4), .RST_VAL(1'b1))
        dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a channel accepts level v at a clock when the last FILT_LEN synchronised
    // samples (din seen SYNC_STAGES clocks earlier) all equal v and v differs from the held level.
    int unsigned flen [2] = '{1, 4};
    int unsigned cmax [2] = '{255, 15};
    logic [1:0]  hq [$];
    logic [1:0]  m_flt [2] = '{2'b11, 2'b11};
    logic [1:0]  m_pe  [2] = '{2'b00, 2'b00};
    logic        m_ea  [2] = '{1'b0, 1'b0};
    logic [1:0]  m_st  [2] = '{2'b00, 2'b00};
    int unsigned m_cnt [2] = '{0, 0};

    function automatic logic hist_at(input int j, input int ch);
        logic [1:0] v;
        if (j < 0) return 1'b1;
        v = hq[j];
        return v[ch];
    endfunction

    always @(posedge clk or negedge n_rst) begin
        int k;
        logic [1:0] acc, lvl, npe;
        logic ok, v, match_r, match_f;
        if (!n_rst) begin
            hq.delete();
            for (int c = 0; c < 2; c++) begin
                m_flt[c] = 2'b11; m_pe[c] = 2'b00; m_ea[c] = 1'b0; m_st[c] = 2'b00; m_cnt[c] = 0;
            end
        end else begin
            k = hq.size();
            match_r = (mode == 2'b00) || (mode == 2'b10);
            match_f = (mode == 2'b01) || (mode == 2'b10);
            for (int c = 0; c < 2; c++) begin
                for (int ch = 0; ch < 2; ch++) begin
                    v  = hist_at(k - int'(S), ch);
                    ok = (v != m_flt[c][ch]);
                    for (int j = 1; j < int'(flen[c]); j++)
                        if (hist_at(k - int'(S) - j, ch) != v) ok = 1'b0;
                    acc[ch] = ok;
                    lvl[ch] = v;
                end
                if (clear) m_cnt[c] = (m_pe[c] != 2'b00) ? 1 : 0;
                else if (m_pe[c] != 2'b00 && m_cnt[c] < cmax[c]) m_cnt[c] = m_cnt[c] + 1;
                m_st[c] = (clear ? 2'b00 : m_st[c]) | m_pe[c];
                for (int ch = 0; ch < 2; ch++)
                    npe[ch] = acc[ch] && (lvl[ch] ? match_r : match_f);
                m_pe[c]  = npe;
                m_ea[c]  = (acc == 2'b11) && ((lvl == 2'b11 && match_r) || (lvl == 2'b00 && match_f));
                m_flt[c] = m_flt[c] ^ acc;
            end
            hq.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pulse0",  32'(bus0.edge_pulse),  32'(m_pe[0]));
            chk("all0",    32'(bus0.edge_all),    32'(m_ea[0]));
            chk("sticky0", 32'(bus0.edge_sticky), 32'(m_st[0]));
            chk("count0",  32'(bus0.edge_count),  32'(m_cnt[0]));
            chk("pulse1",  32'(bus1.edge_pulse),  32'(m_pe[1]));
            chk("all1",    32'(bus1.edge_all),    32'(m_ea[1]));
            chk("sticky1", 32'(bus1.edge_sticky), 32'(m_st[1]));
            chk("count1",  32'(bus1.edge_count),  32'(m_cnt[1]));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    initial begin
        int b;
        n_rst = 1'b0; din = 2'b00; mode = 2'b10; clear = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        step(3);

        // Both channels fall out of reset idle together
        n_rst = 1'b1;
        step(3);
        @(negedge clk);
        chk("t1_pulse0", 32'(bus0.edge_pulse), 32'd3);
        chk("t1_all0",   32'(bus0.edge_all),   32'd1);
        step();
        @(negedge clk);
        chk("t1_pulse0_end", 32'(bus0.edge_pulse),  32'd0);
        chk("t1_count0",     32'(bus0.edge_count),  32'd1);
        chk("t1_sticky0",    32'(bus0.edge_sticky), 32'd3);
        step(2);
        @(negedge clk);
        chk("t1_pulse1_f4", 32'(bus1.edge_pulse), 32'd3);
        chk("t1_all1_f4",   32'(bus1.edge_all),   32'd1);

        // Glitch of 3 cycles is filtered; 4+ cycles is accepted 6 cycles after the change
        din = 2'b11; step(20); clr(); step(2);
        din = 2'b10; step(3); din = 2'b11; step(12);
        @(negedge clk);
        chk("t2_glitch_count1", 32'(bus1.edge_count), 32'd0);
        din = 2'b10; step(5);
        @(negedge clk);
        chk("t2_early_pulse1", 32'(bus1.edge_pulse), 32'd0);
        step();
        @(negedge clk);
        chk("t2_pulse1", 32'(bus1.edge_pulse), 32'd1);
        din = 2'b11; step(10);

        // Rising-only and falling-only on ch1
        clr(); mode = 2'b00;
        din = 2'b01; step(5); din = 2'b11; step(10);
        @(negedge clk);
        chk("t3_rise_count0",  32'(bus0.edge_count),  32'd1);
        chk("t3_rise_sticky0", 32'(bus0.edge_sticky), 32'd2);
        clr(); mode = 2'b01;
        din = 2'b01; step(5); din = 2'b11; step(10);
        @(negedge clk);
        chk("t3_fall_count0", 32'(bus0.edge_count), 32'd1);

        // Coincident vs skewed transitions
        mode = 2'b10; clr();
        din = 2'b10; step(); din = 2'b00; step(10);
        @(negedge clk);
        chk("t4_skew_count0", 32'(bus0.edge_count), 32'd2);
        din = 2'b11; step(10);

        // Saturation on the 4-bit counter, then clear with and without a coincident pulse
        clr();
        for (int i = 0; i < 20; i++) begin
            din[0] = ~din[0]; step(6);
        end
        @(negedge clk);
        chk("t5_sat_count1", 32'(bus1.edge_count), 32'd15);
        din[0] = ~din[0]; step(6);
        clear = 1'b1; step(); clear = 1'b0;
        @(negedge clk);
        chk("t5_clr_pulse_count1",  32'(bus1.edge_count),     32'd1);
        chk("t5_clr_pulse_sticky1", 32'(bus1.edge_sticky[0]), 32'd1);
        step(3); clr();
        @(negedge clk);
        chk("t5_clr_count1",  32'(bus1.edge_count),  32'd0);
        chk("t5_clr_sticky1", 32'(bus1.edge_sticky), 32'd0);
        din = 2'b11; step(10);

        // Disabled mode, then re-enable with static lines
        clr(); mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            din = ~din; step(6);
        end
        mode = 2'b10; step(10);
        @(negedge clk);
        chk("t6_disabled_count0", 32'(bus0.edge_count), 32'd0);
        chk("t6_disabled_count1", 32'(bus1.edge_count), 32'd0);
        din = 2'b00; step(8);
        @(negedge clk);
        chk("t6_reenable_count0", 32'(bus0.edge_count), 32'd1);
        din = 2'b11; step(10);

        // Reset two cycles into a FILT_LEN=4 count discards the partial count
        clr();
        din = 2'b10; step(4);
        n_rst = 1'b0; din = 2'b11;
        @(negedge clk);
        chk("t6_rst_count0", 32'(bus0.edge_count), 32'd0);
        chk("t6_rst_pulse1", 32'(bus1.edge_pulse), 32'd0);
        step(3); n_rst = 1'b1; step(10);
        @(negedge clk);
        chk("t6_rst_after_count1", 32'(bus1.edge_count), 32'd0);

        // Randomised traffic: glitches, mode flips, clears and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = int'($urandom_range(0, 1));
                din[b] = ~din[b];
            end
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            clear = ($urandom_range(0, 29) == 0);
            n_rst = ($urandom_range(0, 499) != 0);
            step();
        end
        n_rst = 1'b1; clear = 1'b0;
        step(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
